// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use, taken branches, data-memory waits, watchdog.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall_cycles / flush_count counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned TO_W        = 7,
  localparam int unsigned REG_W      = 5,
  localparam int unsigned PERF_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             mem_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            timeout_hit;
  logic            branch_act;
  logic            load_use;
  logic            mem_stall;

  assign load_use = ex_MemRead && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_stall = mem_req && !mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_hit) mem_timeout <= 1'b1;
    end
  end

  // Mealy enables/flushes; reset forces every register into a flushed, frozen state
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_hit  = 1'b0;
    branch_act   = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;

    case (state)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_write = 1'b0;
          mem_wb_flush = 1'b1;
          if (state == RUN) begin
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = TO_W'(1);
          end else if (wait_cnt == TO_W'(MEM_TIMEOUT)) begin
            state_nxt   = ERROR;
            timeout_hit = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + TO_W'(1);
          end
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
          if (ex_branch_taken) begin
            branch_act  = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      end
      ERROR: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
      end
      default: state_nxt = RUN;
    endcase

    if (!reset) begin
      branch_act   = 1'b0;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  assign halted = (state == ERROR);

`ifdef PIPE_PERF_CNT_EN
  // Saturating performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((state != ERROR) && !pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + PERF_W'(1);
      if (branch_act && (flush_count != '1))
        flush_count <= flush_count + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table-driven RUN-state vectors plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 4;

  // {pc, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, if_id_f, id_ex_f, ex_mem_f, mem_wb_f, halted}
  localparam logic [9:0] E_NORM  = 10'b11111_0000_0;
  localparam logic [9:0] E_LU    = 10'b00111_0100_0;
  localparam logic [9:0] E_BR    = 10'b11111_1100_0;
  localparam logic [9:0] E_STALL = 10'b00000_0001_0;
  localparam logic [9:0] E_ERR   = 10'b00000_0000_1;
  localparam logic [9:0] E_RST   = 10'b00000_1111_0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_MemRead, ex_branch_taken, mem_req, mem_ready;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted, mem_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  logic [9:0] obs;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .TO_W(3)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .mem_timeout(mem_timeout)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  assign obs = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted};

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, memread, br, req, rdy;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[10];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic [4:0] rd, input logic mr,
                              input logic br, input logic req, input logic rdy,
                              input logic [9:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.use1 = u1; v.use2 = u2; v.rd = rd;
    v.memread = mr; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic set_in(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
    ex_rd = v.rd; ex_MemRead = v.memread; ex_branch_taken = v.br;
    mem_req = v.req; mem_ready = v.rdy;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Apply a vector mid-cycle and check the Mealy outputs before the next rising edge
  task automatic step(input string nm, input vec_t v);
    @(negedge clk);
    set_in(v);
    #2;
    chk(nm, 32'(obs), 32'(v.exp));
  endtask

  task automatic pulse_reset(input string nm);
    @(negedge clk);
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));
    reset = 1'b0;
    #2;
    chk({nm, "_outs"}, 32'(obs), 32'(E_RST));
    chk({nm, "_timeout"}, 32'(mem_timeout), 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM));

    tbl[0] = mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 0, E_NORM);
    tbl[1] = mk(5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, E_LU);
    tbl[2] = mk(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, E_NORM);
    tbl[3] = mk(5'd7, 5'd2, 1, 0, 5'd7, 1, 0, 0, 0, E_LU);
    tbl[4] = mk(5'd7, 5'd2, 0, 1, 5'd7, 1, 0, 0, 0, E_NORM);
    tbl[5] = mk(5'd9, 5'd9, 1, 1, 5'd9, 0, 0, 0, 0, E_NORM);
    tbl[6] = mk(5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, E_BR);
    tbl[7] = mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0, 0, E_BR);
    tbl[8] = mk(5'd4, 5'd6, 1, 1, 5'd4, 1, 0, 1, 1, E_LU);
    tbl[9] = mk(5'd8, 5'd6, 1, 0, 5'd6, 1, 0, 0, 0, E_NORM);

    // Reset held low for two cycles, then released
    step("rst_cyc0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    step("rst_cyc1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));
    reset = 1'b1;
    step("rst_release", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM));

    for (int i = 0; i < 10; i++) begin
      step($sformatf("tbl%0d", i), tbl[i]);
    end

    // Memory wait: three stalled cycles (branch deferred), then completion applies the branch
    step("mw_stall0", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_STALL));
    step("mw_stall1", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_STALL));
    step("mw_stall2_br", mk(5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 1, 0, E_STALL));
    step("mw_done_br", mk(5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 1, 1, E_BR));
    step("mw_after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM));
    chk("mw_halted", 32'(halted), 32'd0);

    // Wait ended by mem_req dropping
    step("mw_req_stall", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_STALL));
    step("mw_req_drop_lu", mk(5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, E_LU));

    // Watchdog: five stalled cycles, then ERROR with sticky timeout
    for (int i = 0; i < 5; i++) begin
      step($sformatf("to_stall%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_STALL));
      chk($sformatf("to_flag%0d", i), 32'(mem_timeout), 32'd0);
    end
    step("to_err", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_ERR));
    chk("to_sticky0", 32'(mem_timeout), 32'd1);
    step("to_err_ready", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_ERR));
    step("to_err_br", mk(5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, E_ERR));
    chk("to_sticky1", 32'(mem_timeout), 32'd1);
    pulse_reset("to_rst");
    step("to_recover", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM));
    chk("to_cleared", 32'(mem_timeout), 32'd0);

    // Reset mid-wait returns to RUN with the counter cleared
    step("mr_stall0", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_STALL));
    step("mr_stall1", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_STALL));
    pulse_reset("mr_rst");
    for (int i = 0; i < 5; i++) begin
      step($sformatf("mr_full%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_STALL));
    end
    step("mr_err", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_ERR));
    pulse_reset("mr_rst2");
    step("mr_run", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM));

`ifdef PIPE_PERF_CNT_EN
    chk("perf_zero_stall", stall_cycles, 32'd0);
    chk("perf_zero_flush", flush_count, 32'd0);
    step("perf_lu", mk(5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, E_LU));
    step("perf_mw0", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_STALL));
    step("perf_mw1", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_STALL));
    step("perf_mwdone", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, E_NORM));
    step("perf_br", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR));
    step("perf_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM));
    chk("perf_stall_cycles", stall_cycles, 32'd3);
    chk("perf_flush_count", flush_count, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
